// File: rtl/even_parity_pkg.sv
// Shared types and constants for the even-parity serial receiver.
package even_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/even_parity_rx_if.sv
// Received-word handshake: producer drives word/status, consumer drives out_ready.
interface even_parity_rx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] dout;
  logic              out_valid;
  logic              out_ready;
  logic              par_err;
  logic              overrun;

  modport master (output dout, output out_valid, output par_err, output overrun, input out_ready);
  modport slave  (input dout, input out_valid, input par_err, input overrun, output out_ready);
endinterface

// File: rtl/even_parity_rx_parity_acc.sv
// Running XOR parity accumulator; result visible the cycle after each enabled bit.
// Clear has priority over enable; no backpressure.
module parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic bit_in,
  output logic par
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par <= 1'b0;
    end else if (clear) begin
      par <= 1'b0;
    end else if (enable) begin
      par <= par ^ bit_in;
    end
  end

endmodule

// File: rtl/even_parity_rx.sv
// Serial even-parity receiver: start bit, DATA_W bits LSB-first, parity; word valid DATA_W+1 cycles after start.
// Single holding register; a frame completing while it is full and unconsumed is dropped with an overrun pulse. Optional err_cnt via EVEN_PARITY_RX_ERR_CNT_EN.
module even_parity_rx
  import even_parity_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic busy,
`ifdef EVEN_PARITY_RX_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  even_parity_rx_if.master rx
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  typedef logic [DATA_W-1:0] data_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt;
  data_t            shreg;
  logic             par;
  logic             start;
  logic             frame_done;
  logic             frame_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    frame_done = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (din) begin
          start   = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_W'(DATA_W - 1)) begin
          state_d = PARITY;
        end
      end
      PARITY: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  parity_acc u_parity_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .enable (state_q == DATA),
    .bit_in (din),
    .par    (par)
  );

  // din here is the parity bit itself, sampled on the completion edge
  assign frame_err = par ^ din;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      shreg        <= '0;
      rx.dout      <= '0;
      rx.out_valid <= 1'b0;
      rx.par_err   <= 1'b0;
      rx.overrun   <= 1'b0;
    end else begin
      rx.overrun <= 1'b0;
      if (state_q == DATA) begin
        shreg <= (shreg >> 1) | (data_t'(din) << (DATA_W - 1));
        cnt   <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
      if (frame_done) begin
        if (!rx.out_valid || rx.out_ready) begin
          rx.dout      <= shreg;
          rx.par_err   <= frame_err;
          rx.out_valid <= 1'b1;
        end else begin
          rx.overrun <= 1'b1;
        end
      end else if (rx.out_valid && rx.out_ready) begin
        rx.out_valid <= 1'b0;
      end
    end
  end

`ifdef EVEN_PARITY_RX_ERR_CNT_EN
  // Counts every bad frame, including ones dropped on overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (frame_done && frame_err && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_even_parity_rx.sv
// Directed bench for even_parity_rx: framing, parity, handshake, overrun, mid-frame reset, optional err_cnt.
module tb_even_parity_rx;
  import even_parity_pkg::*;

  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic busy;
`ifdef EVEN_PARITY_RX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  even_parity_rx_if #(.DATA_W(DATA_W)) rx_if ();

  even_parity_rx #(.DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .busy    (busy),
`ifdef EVEN_PARITY_RX_ERR_CNT_EN
    .err_cnt (err_cnt),
`endif
    .rx      (rx_if.master)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete frame; returns just after the edge that samples the parity bit.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic rdy_at_par);
    din = 1'b1;
    step();
    for (int i = 0; i < DATA_W; i++) begin
      din = d[i];
      step();
    end
    if (rdy_at_par) rx_if.out_ready = 1'b1;
    din = p;
    step();
    if (rdy_at_par) rx_if.out_ready = 1'b0;
    din = 1'b0;
  endtask

  initial begin
    rx_if.out_ready = 1'b0;
    #12;
    check("rst_valid",   32'(rx_if.out_valid), 32'h0);
    check("rst_dout",    32'(rx_if.dout),      32'h0);
    check("rst_par_err", 32'(rx_if.par_err),   32'h0);
    check("rst_overrun", 32'(rx_if.overrun),   32'h0);
    check("rst_busy",    32'(busy),            32'h0);
`ifdef EVEN_PARITY_RX_ERR_CNT_EN
    check("rst_err_cnt", 32'(err_cnt),         32'h0);
`endif
    step();
    rst = 1'b1;
    step();

    // Good frame 0xA5, consumer always ready
    rx_if.out_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b0);
    check("a5_valid",   32'(rx_if.out_valid), 32'h1);
    check("a5_dout",    32'(rx_if.dout),      32'hA5);
    check("a5_par_err", 32'(rx_if.par_err),   32'h0);
    check("a5_busy",    32'(busy),            32'h0);
    step();
    check("a5_consumed", 32'(rx_if.out_valid), 32'h0);

    // Same frame with wrong parity bit
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5b_dout",    32'(rx_if.dout),    32'hA5);
    check("a5b_par_err", 32'(rx_if.par_err), 32'h1);
`ifdef EVEN_PARITY_RX_ERR_CNT_EN
    check("a5b_err_cnt", 32'(err_cnt),       32'h1);
`endif
    step();
    check("a5b_consumed", 32'(rx_if.out_valid), 32'h0);

    // Back-to-back frames, consumer stalled: second one dropped
    rx_if.out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0);
    check("b2b_first_valid",   32'(rx_if.out_valid), 32'h1);
    check("b2b_first_dout",    32'(rx_if.dout),      32'h3C);
    check("b2b_first_overrun", 32'(rx_if.overrun),   32'h0);
    send_frame(8'h01, 1'b1, 1'b0);
    check("b2b_overrun",     32'(rx_if.overrun),   32'h1);
    check("b2b_hold_dout",   32'(rx_if.dout),      32'h3C);
    check("b2b_hold_perr",   32'(rx_if.par_err),   32'h0);
    step();
    check("b2b_overrun_end", 32'(rx_if.overrun),   32'h0);
    check("b2b_still_dout",  32'(rx_if.dout),      32'h3C);
    check("b2b_still_valid", 32'(rx_if.out_valid), 32'h1);
`ifdef EVEN_PARITY_RX_ERR_CNT_EN
    check("b2b_err_cnt",     32'(err_cnt),         32'h1);
`endif
    rx_if.out_ready = 1'b1;
    step();
    check("b2b_drained", 32'(rx_if.out_valid), 32'h0);
    rx_if.out_ready = 1'b0;

    // Consume on the very edge the next frame completes
    send_frame(8'h3C, 1'b0, 1'b0);
    check("same_edge_pre_valid", 32'(rx_if.out_valid), 32'h1);
    send_frame(8'h7F, 1'b1, 1'b1);
    check("same_edge_dout",    32'(rx_if.dout),      32'h7F);
    check("same_edge_valid",   32'(rx_if.out_valid), 32'h1);
    check("same_edge_overrun", 32'(rx_if.overrun),   32'h0);
    check("same_edge_perr",    32'(rx_if.par_err),   32'h0);
    rx_if.out_ready = 1'b1;
    step();
    check("same_edge_drained", 32'(rx_if.out_valid), 32'h0);

    // Reset in the middle of a 0xFF frame
    din = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    check("midrst_busy_before", 32'(busy), 32'h1);
    rst = 1'b0;
    #1;
    check("midrst_busy",  32'(busy),            32'h0);
    check("midrst_valid", 32'(rx_if.out_valid), 32'h0);
    check("midrst_dout",  32'(rx_if.dout),      32'h0);
    din = 1'b0;
    step();
    rst = 1'b1;
    step();
    step();
    check("midrst_idle_busy",  32'(busy),            32'h0);
    check("midrst_idle_valid", 32'(rx_if.out_valid), 32'h0);
    send_frame(8'h12, 1'b0, 1'b0);
    check("post_rst_valid", 32'(rx_if.out_valid), 32'h1);
    check("post_rst_dout",  32'(rx_if.dout),      32'h12);
    check("post_rst_perr",  32'(rx_if.par_err),   32'h0);
    step();
    check("post_rst_consumed", 32'(rx_if.out_valid), 32'h0);
    repeat (12) step();
    check("post_rst_no_extra", 32'(rx_if.out_valid), 32'h0);

`ifdef EVEN_PARITY_RX_ERR_CNT_EN
    check("sat_start", 32'(err_cnt), 32'h0);
    for (int n = 0; n < 300; n++) begin
      send_frame(8'h00, 1'b1, 1'b0);
    end
    step();
    check("sat_err_cnt", 32'(err_cnt), 32'hFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
